// File: rtl/muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider owning the HI/LO pair.
// One iteration per cycle in RUN, then a single FIX cycle for the sign correction.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0]   ONE  = 1;
   localparam logic [2*WIDTH-1:0] ONE2 = 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             r_state, w_next;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opd, r_hi, r_lo;
   logic               r_div, r_neg_q, r_neg_r, r_done, r_dz;

   logic               w_accept, w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_abs, w_b_abs;
   logic [WIDTH:0]     w_sum, w_shift;
   logic [WIDTH-1:0]   w_diff;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

   assign w_accept = (r_state == S_IDLE) && start && !flush;
   assign w_a_neg  = !op[0] && a[WIDTH-1];
   assign w_b_neg  = !op[0] && b[WIDTH-1];
   assign w_a_abs  = w_a_neg ? (~a + ONE) : a;
   assign w_b_abs  = w_b_neg ? (~b + ONE) : b;

   // Multiply: upper half accumulates, multiplier shifts out of the low end
   assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opd} : '0);
   assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

   // Divide: upper half is the partial remainder, lower half dividend/quotient
   assign w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_ge      = w_shift >= {1'b0, r_opd};
   assign w_diff    = w_shift[WIDTH-1:0] - r_opd;
   assign w_div_nxt = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {r_acc[2*WIDTH-2:0], 1'b0};

   assign w_prod_fix = r_neg_q ? (~r_acc + ONE2) : r_acc;
   assign w_quo_fix  = r_neg_q ? (~r_acc[WIDTH-1:0] + ONE)
                               : r_acc[WIDTH-1:0];
   assign w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + ONE)
                               : r_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept && !op[2]) w_next = S_RUN;
         S_RUN: begin
            if (flush)                          w_next = S_IDLE;
            else if (r_cnt == CW'(WIDTH - 1))   w_next = S_FIX;
         end
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opd   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept && !op[2]) begin
                  r_cnt   <= '0;
                  r_div   <= op[1];
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_dz    <= 1'b0;
                  r_opd   <= op[1] ? w_b_abs : w_a_abs;
                  r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_a_abs : w_b_abs)};
               end else if (w_accept && op[2:1] == 2'b10) begin
                  r_dz <= 1'b0;
                  if (op[0]) r_lo <= a;
                  else       r_hi <= a;
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + CW'(1);
               r_acc <= r_div ? w_div_nxt : w_mul_nxt;
            end
            S_FIX: begin
               if (!flush) begin
                  r_done <= 1'b1;
                  r_dz   <= r_div && (r_opd == '0);
                  if (r_div) begin
                     r_hi <= w_rem_fix;
                     r_lo <= (r_opd == '0) ? '1 : w_quo_fix;
                  end else begin
                     r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod_fix[WIDTH-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign div_by_zero = r_dz;
   assign hi          = r_hi;
   assign lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/flag queued at issue,
// checked when done pulses; also covers flush, busy-ignore and async reset.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, flush;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o,
                                  input logic [W-1:0] x, y);
      exp_t        e;
      longint      sx, sy, q, r;
      logic [63:0] p, ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      e  = '0;
      case (o)
         3'd0: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd1: begin p = ux * uy; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd2, 3'd3: begin
            if (y == 0) begin
               e.hi = x; e.lo = '1; e.dz = 1'b1;
            end else if (o == 3'd2) begin
               q = sx / sy; r = sx % sy;
               e.lo = q[31:0]; e.hi = r[31:0];
            end else begin
               p = ux / uy; e.lo = p[31:0];
               p = ux % uy; e.hi = p[31:0];
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, y);
      exp_t e;
      int   cyc, bcnt;
      op = o; a = x; b = y; start = 1'b1;
      step();
      start = 1'b0;
      sb.push_back(model(o, x, y));
      chk("busy_after_accept", busy, 1);
      bcnt = busy ? 1 : 0;
      cyc  = 0;
      while (!done && cyc < 100) begin
         step();
         cyc++;
         if (busy) bcnt++;
      end
      chk("done_seen", done, 1);
      chk("latency", cyc, 33);
      chk("busy_cycles", bcnt, 33);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("hi", hi, e.hi);
         chk("lo", lo, e.lo);
         chk("div_by_zero", div_by_zero, e.dz);
      end
      step();
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      int ndone;
      logic [2:0] ro;
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      op = 3'd0; a = '0; b = '0;
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_by_zero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      reset = 1'b0;
      step();

      run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
      run_op(3'd3, 32'h0000_0007, 32'h0000_0002);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd3, 32'h0000_0005, 32'h0000_0000);
      run_op(3'd2, 32'h8000_0003, 32'h0000_0000);
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
      for (int i = 0; i < 10; i++) begin
         ro = 3'($urandom_range(0, 3));
         run_op(ro, $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 9))
                                          : $urandom);
      end

      op = 3'd4; a = 32'h1234_5678; start = 1'b1;
      step();
      start = 1'b0;
      chk("mthi", hi, 32'h1234_5678);
      op = 3'd5; a = 32'hCAFE_F00D; start = 1'b1;
      step();
      start = 1'b0;
      chk("mtlo", lo, 32'hCAFE_F00D);
      chk("mt_no_done", done, 0);

      op = 3'd4; a = 32'h0; start = 1'b1; flush = 1'b1;
      step();
      start = 1'b0; flush = 1'b0;
      chk("flush_idle_hi", hi, 32'h1234_5678);
      chk("flush_idle_busy", busy, 0);

      op = 3'd1; a = 32'd3; b = 32'd4; start = 1'b1;
      step();
      start = 1'b0;
      chk("flush_op_busy", busy, 1);
      repeat (5) step();
      op = 3'd4; a = 32'hDEAD_BEEF; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy_low", busy, 0);
      chk("flush_no_done", done, 0);
      ndone = 0;
      repeat (40) begin
         step();
         if (done) ndone++;
      end
      chk("flush_done_count", ndone, 0);
      chk("flush_hi_kept", hi, 32'h1234_5678);
      chk("flush_lo_kept", lo, 32'hCAFE_F00D);

      op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      #1 reset = 1'b0;
      step();
      run_op(3'd0, 32'hFFFF_FFFD, 32'd7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
